// File: rtl/armleocpu_bpredict.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | armleocpu_bpredict: fetch-side BTB with 2-bit counters and flush sweep.    |
// | Optional statistics enabled by ARMLEOCPU_BPRED_STATS_EN.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module armleocpu_bpredict #(
  parameter int ENTRIES_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic        resp_taken,
  output logic [31:0] resp_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] stat_upd_count,
  output logic [31:0] stat_mispredict_count
);

  localparam int DEPTH = 1 << ENTRIES_W;
  localparam int TAG_W = 30 - ENTRIES_W;

  typedef enum logic [0:0] {SWEEP = 1'b0, IDLE = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ENTRIES_W-1:0] sweep_idx_q, sweep_idx_d;
  logic                 sweep_clr;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_taken_q, resp_taken_d;
  logic [31:0]          resp_target_q, resp_target_d;

  logic             valid_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [29:0]      target_mem [DEPTH];
  logic [1:0]       ctr_mem    [DEPTH];

  logic [ENTRIES_W-1:0] req_idx, upd_idx;
  logic [TAG_W-1:0]     req_tag, upd_tag;
  logic                 req_hit, upd_hit, upd_accept;
  logic [1:0]           upd_old_ctr;
  logic [29:0]          upd_old_target;
  logic                 wr_en;
  logic [1:0]           wr_ctr;
  logic [29:0]          wr_target;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{req_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign req_idx = req_pc[ENTRIES_W+1:2];
  assign req_tag = req_pc[31:ENTRIES_W+2];
  assign upd_idx = upd_pc[ENTRIES_W+1:2];
  assign upd_tag = upd_pc[31:ENTRIES_W+2];

  // Entries are only trusted once a sweep has fully completed.
  assign req_hit = (state_q == IDLE) && valid_mem[req_idx] && (tag_mem[req_idx] == req_tag);
  assign upd_hit = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign upd_accept     = upd_valid && (state_q == IDLE) && !flush;
  assign upd_old_ctr    = ctr_mem[upd_idx];
  assign upd_old_target = target_mem[upd_idx];

  always_comb begin
    wr_en     = 1'b0;
    wr_ctr    = upd_old_ctr;
    wr_target = upd_old_target;
    if (upd_accept) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_ctr    = (upd_old_ctr == 2'b11) ? 2'b11 : upd_old_ctr + 2'b01;
          wr_target = upd_target[31:2];
        end else begin
          wr_ctr    = (upd_old_ctr == 2'b00) ? 2'b00 : upd_old_ctr - 2'b01;
        end
      end else if (upd_taken) begin
        wr_en     = 1'b1;
        wr_ctr    = 2'b10;
        wr_target = upd_target[31:2];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    sweep_clr   = 1'b0;
    case (state_q)
      SWEEP: begin
        sweep_clr   = 1'b1;
        sweep_idx_d = sweep_idx_q + ENTRIES_W'(1);
        if (&sweep_idx_q) state_d = IDLE;
      end
      default: ;
    endcase
    if (flush) begin
      state_d     = SWEEP;
      sweep_idx_d = '0;
    end
  end

  always_comb begin
    resp_valid_d  = req_valid;
    resp_taken_d  = req_valid && req_hit && ctr_mem[req_idx][1];
    resp_target_d = (req_valid && req_hit) ? {target_mem[req_idx], 2'b00} : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SWEEP;
      sweep_idx_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_taken_q  <= 1'b0;
      resp_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      resp_valid_q  <= resp_valid_d;
      resp_taken_q  <= resp_taken_d;
      resp_target_q <= resp_target_d;
    end
  end

  // Sweep and update never write in the same cycle: updates need IDLE.
  always_ff @(posedge clk) begin
    if (sweep_clr) valid_mem[sweep_idx_q] <= 1'b0;
    if (wr_en) begin
      valid_mem[upd_idx]  <= 1'b1;
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= wr_target;
      ctr_mem[upd_idx]    <= wr_ctr;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_taken  = resp_taken_q;
  assign resp_target = resp_target_q;
  assign busy        = (state_q == SWEEP);

`ifdef ARMLEOCPU_BPRED_STATS_EN
  logic [31:0] stat_upd_q, stat_upd_d;
  logic [31:0] stat_mis_q, stat_mis_d;
  logic        upd_mispredict;

  // A taken branch on a miss had no predicted target, so it counts as wrong.
  assign upd_mispredict = (upd_pred_taken != upd_taken) ||
                          (upd_taken && upd_pred_taken &&
                           (!upd_hit || (upd_old_target != upd_target[31:2])));

  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (flush) begin
      stat_upd_d = 32'h0;
      stat_mis_d = 32'h0;
    end else if (upd_accept) begin
      if (~&stat_upd_q) stat_upd_d = stat_upd_q + 32'd1;
      if (upd_mispredict && ~&stat_mis_q) stat_mis_d = stat_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_upd_q <= 32'h0;
      stat_mis_q <= 32'h0;
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_upd_count        = stat_upd_q;
  assign stat_mispredict_count = stat_mis_q;
`else
  logic unused_stats;
  assign unused_stats          = upd_pred_taken;
  assign stat_upd_count        = 32'h0;
  assign stat_mispredict_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_bpredict.sv
`default_nettype none
// Directed self-checking bench for armleocpu_bpredict (ENTRIES_W=6).
module tb_armleocpu_bpredict;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_taken;
  logic [31:0] resp_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        flush;
  logic        busy;
  logic [31:0] stat_upd_count;
  logic [31:0] stat_mispredict_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  always #5 clk = ~clk;

  armleocpu_bpredict #(.ENTRIES_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_target(resp_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .flush(flush), .busy(busy),
    .stat_upd_count(stat_upd_count), .stat_mispredict_count(stat_mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_tgt);
    req_valid = 1'b1;
    req_pc    = pc;
    step();
    req_valid = 1'b0;
    chk({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "_taken"}, {31'b0, resp_taken}, {31'b0, exp_taken});
    chk({tag, "_target"}, resp_target, exp_tgt);
  endtask

  task automatic update(input logic [31:0] pc, input logic taken,
                        input logic [31:0] tgt, input logic pred);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_pred_taken = pred;
    step();
    upd_valid = 1'b0;
  endtask

  // Counts sampled cycles with busy high; optional lookup / update injected mid-sweep.
  task automatic count_busy(input int req_at, input int upd_at, output int n);
    n = 0;
    for (int i = 0; i < 200 && busy === 1'b1; i++) begin
      n++;
      if (i == req_at) begin
        req_valid = 1'b1;
        req_pc    = 32'h100;
      end
      if (i == upd_at) begin
        upd_valid      = 1'b1;
        upd_pc         = 32'h1000;
        upd_taken      = 1'b1;
        upd_target     = 32'h7000;
        upd_pred_taken = 1'b0;
      end
      step();
      upd_valid = 1'b0;
      if (i == req_at) begin
        req_valid = 1'b0;
        chk("sweep_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("sweep_resp_taken", {31'b0, resp_taken}, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; flush = 1'b0;
    repeat (3) step();
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_taken", {31'b0, resp_taken}, 32'd0);
    chk("rst_resp_target", resp_target, 32'h0);
    chk("rst_stat_upd", stat_upd_count, 32'h0);
    chk("rst_stat_mis", stat_mispredict_count, 32'h0);
    rst = 1'b0;

    count_busy(5, -1, cnt);
    chk("init_sweep_len", cnt, 32'd64);
    chk("init_sweep_done", {31'b0, busy}, 32'd0);

    // Allocate and hit; alias with same index but different tag misses.
    update(32'h1000, 1'b1, 32'h2000, 1'b0);
    lookup("alloc_hit", 32'h1000, 1'b1, 32'h2000);
    lookup("alias_miss", 32'h2000, 1'b0, 32'h0);

    // Counter walks down from 10 and saturates at 00.
    update(32'h1000, 1'b0, 32'h0, 1'b1);
    lookup("nt1", 32'h1000, 1'b0, 32'h2000);
    update(32'h1000, 1'b0, 32'h0, 1'b0);
    update(32'h1000, 1'b0, 32'h0, 1'b0);
    lookup("nt3_sat", 32'h1000, 1'b0, 32'h2000);
    update(32'h1000, 1'b1, 32'h2000, 1'b0);
    lookup("t1_from00", 32'h1000, 1'b0, 32'h2000);
    update(32'h1000, 1'b1, 32'h2000, 1'b0);
    lookup("t2_from01", 32'h1000, 1'b1, 32'h2000);

    // Saturation at 11 and target overwrite.
    update(32'h1000, 1'b1, 32'h3000, 1'b1);
    update(32'h1000, 1'b1, 32'h3000, 1'b1);
    update(32'h1000, 1'b0, 32'h0, 1'b1);
    lookup("sat11_nt", 32'h1000, 1'b1, 32'h3000);
    update(32'h1000, 1'b0, 32'h0, 1'b1);
    lookup("sat11_nt2", 32'h1000, 1'b0, 32'h3000);

    // Same-cycle lookup and allocating update: read-before-write.
    req_valid = 1'b1; req_pc = 32'h1040;
    update(32'h1040, 1'b1, 32'h5000, 1'b0);
    req_valid = 1'b0;
    chk("rbw_valid", {31'b0, resp_valid}, 32'd1);
    chk("rbw_taken", {31'b0, resp_taken}, 32'd0);
    chk("rbw_target", resp_target, 32'h0);
    lookup("rbw_after", 32'h1040, 1'b1, 32'h5000);

    // Flush in IDLE, then restart it at sweep cycle 10; update during sweep dropped.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd1);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    count_busy(-1, 20, cnt);
    chk("reflush_sweep_len", cnt, 32'd64);
    lookup("post_flush_1000", 32'h1000, 1'b0, 32'h0);
    lookup("post_flush_1040", 32'h1040, 1'b0, 32'h0);

    // Statistics (constant zero when the feature is compiled out).
    chk("stat_upd_start", stat_upd_count, 32'h0);
    update(32'h1000, 1'b1, 32'h2000, 1'b0);
    update(32'h1000, 1'b1, 32'h2000, 1'b1);
    update(32'h1000, 1'b0, 32'h0, 1'b1);
    update(32'h1000, 1'b0, 32'h0, 1'b0);
    update(32'h1080, 1'b0, 32'h0, 1'b0);
`ifdef ARMLEOCPU_BPRED_STATS_EN
    chk("stat_upd_5", stat_upd_count, 32'd5);
    chk("stat_mis_2", stat_mispredict_count, 32'd2);
`else
    chk("stat_upd_off", stat_upd_count, 32'd0);
    chk("stat_mis_off", stat_mispredict_count, 32'd0);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stat_upd_flush", stat_upd_count, 32'h0);
    chk("stat_mis_flush", stat_mispredict_count, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
